// File: rtl/ex_mem_stage_reg_pkg.sv
// Shared pipeline types for the EX/MEM boundary: NZCV bit positions,
// B.cond encodings and the bundle of MEM-side control bits.
package ex_mem_stage_reg_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef struct packed {
    logic mem_to_reg;
    logic mem_write;
    logic mem_read;
    logic reg_write;
    logic branch_link;
    logic valid;
  } ex_mem_ctrl_t;

endpackage

// File: rtl/ex_mem_stage_reg_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM register, including
// stall/flush; the stage register is the slave, the pipeline the master.
interface ex_mem_stage_reg_if #(
  parameter int DW = 64,
  parameter int RW = 5
);
  logic          stall;
  logic          flush;
  logic [DW-1:0] alu_result;
  logic          alu_n, alu_z, alu_c, alu_v;
  logic [DW-1:0] rd2_EX;
  logic [RW-1:0] targetReg_EX;
  logic [DW-1:0] pc_plus4_EX;
  logic [DW-1:0] br_target;
  logic [DW-1:0] rd1_EX;
  logic          set_flags_EX, branch_EX, uncondBr_EX, branchReg_EX, branchLink_EX;
  logic          memToReg_EX, memWrite_EX, memRead_EX, RegWrite_EX;
  logic          cbz_EX, cbnz_EX;
  logic [3:0]    cond_EX;

  logic          br_taken;
  logic [DW-1:0] pc_next_target;
  logic [DW-1:0] alu_result_MEM, rd2_MEM, pc_plus4_MEM;
  logic [RW-1:0] targetReg_MEM;
  logic          memToReg_MEM, memWrite_MEM, memRead_MEM, RegWrite_MEM, branchLink_MEM, valid_MEM;
  logic [3:0]    flags_q;

  modport slave (
    input  stall, flush, alu_result, alu_n, alu_z, alu_c, alu_v, rd2_EX, targetReg_EX,
           pc_plus4_EX, br_target, rd1_EX, set_flags_EX, branch_EX, uncondBr_EX,
           branchReg_EX, branchLink_EX, memToReg_EX, memWrite_EX, memRead_EX,
           RegWrite_EX, cbz_EX, cbnz_EX, cond_EX,
    output br_taken, pc_next_target, alu_result_MEM, rd2_MEM, pc_plus4_MEM, targetReg_MEM,
           memToReg_MEM, memWrite_MEM, memRead_MEM, RegWrite_MEM, branchLink_MEM,
           valid_MEM, flags_q
  );

  modport master (
    output stall, flush, alu_result, alu_n, alu_z, alu_c, alu_v, rd2_EX, targetReg_EX,
           pc_plus4_EX, br_target, rd1_EX, set_flags_EX, branch_EX, uncondBr_EX,
           branchReg_EX, branchLink_EX, memToReg_EX, memWrite_EX, memRead_EX,
           RegWrite_EX, cbz_EX, cbnz_EX, cond_EX,
    input  br_taken, pc_next_target, alu_result_MEM, rd2_MEM, pc_plus4_MEM, targetReg_MEM,
           memToReg_MEM, memWrite_MEM, memRead_MEM, RegWrite_MEM, branchLink_MEM,
           valid_MEM, flags_q
  );
endinterface

// File: rtl/branch_cond_eval.sv
// ARM-style condition evaluation of a 4-bit cond field against NZCV.
module branch_cond_eval
  import ex_mem_stage_reg_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       taken
);
  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_HS: taken = c;
      COND_LO: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !(c && !z);
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = !(!z && (n == v));
      default: taken = 1'b1;  // AL and its 0xF alias both mean "always"
    endcase
  end
endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: branch resolution, NZCV flag register, and
// the registered MEM-side bundle with stall (hold) and flush (bubble).
module ex_mem_stage_reg
  import ex_mem_stage_reg_pkg::*;
#(
  parameter int DW = 64,
  parameter int RW = 5
) (
  input logic               clk,
  input logic               reset_n,
  ex_mem_stage_reg_if.slave bus
);
  ex_mem_ctrl_t  ctrl_q, ctrl_d;
  logic [DW-1:0] alu_q, alu_d;
  logic [DW-1:0] rd2_q, rd2_d;
  logic [DW-1:0] pc4_q, pc4_d;
  logic [RW-1:0] tgt_q, tgt_d;
  logic [3:0]    flags_q, flags_d;
  logic          cond_taken;

  // B.cond uses the registered flags so a flag-setter directly ahead needs no bubble.
  branch_cond_eval u_cond (
    .cond  (bus.cond_EX),
    .nzcv  (flags_q),
    .taken (cond_taken)
  );

  // CBZ/CBNZ sees Rt through the ALU, so the live Z flag is the right one.
  assign bus.br_taken = bus.uncondBr_EX ? 1'b1 :
                        bus.branch_EX   ? (bus.cbz_EX ? (bus.alu_z ^ bus.cbnz_EX) : cond_taken) :
                                          1'b0;

  assign bus.pc_next_target = bus.branchReg_EX ? bus.rd1_EX : bus.br_target;

  always_comb begin
    // NOTE: every next-state value defaults to hold before the priority chain,
    // so no path leaves a signal unassigned and no latch is inferred.
    ctrl_d  = ctrl_q;
    alu_d   = alu_q;
    rd2_d   = rd2_q;
    pc4_d   = pc4_q;
    tgt_d   = tgt_q;
    flags_d = flags_q;
    if (!bus.stall) begin
      if (bus.flush) begin
        ctrl_d = '0;
        alu_d  = '0;
        rd2_d  = '0;
        pc4_d  = '0;
        tgt_d  = '0;
      end else begin
        ctrl_d.mem_to_reg  = bus.memToReg_EX;
        ctrl_d.mem_write   = bus.memWrite_EX;
        ctrl_d.mem_read    = bus.memRead_EX;
        ctrl_d.reg_write   = bus.RegWrite_EX;
        ctrl_d.branch_link = bus.branchLink_EX;
        ctrl_d.valid       = 1'b1;
        alu_d              = bus.alu_result;
        rd2_d              = bus.rd2_EX;
        pc4_d              = bus.pc_plus4_EX;
        tgt_d              = bus.targetReg_EX;
        if (bus.set_flags_EX) begin
          flags_d[FLAG_N] = bus.alu_n;
          flags_d[FLAG_Z] = bus.alu_z;
          flags_d[FLAG_C] = bus.alu_c;
          flags_d[FLAG_V] = bus.alu_v;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      alu_q   <= '0;
      rd2_q   <= '0;
      pc4_q   <= '0;
      tgt_q   <= '0;
      flags_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      rd2_q   <= rd2_d;
      pc4_q   <= pc4_d;
      tgt_q   <= tgt_d;
      flags_q <= flags_d;
    end
  end

  assign bus.alu_result_MEM = alu_q;
  assign bus.rd2_MEM        = rd2_q;
  assign bus.pc_plus4_MEM   = pc4_q;
  assign bus.targetReg_MEM  = tgt_q;
  assign bus.memToReg_MEM   = ctrl_q.mem_to_reg;
  assign bus.memWrite_MEM   = ctrl_q.mem_write;
  assign bus.memRead_MEM    = ctrl_q.mem_read;
  assign bus.RegWrite_MEM   = ctrl_q.reg_write;
  assign bus.branchLink_MEM = ctrl_q.branch_link;
  assign bus.valid_MEM      = ctrl_q.valid;
  assign bus.flags_q        = flags_q;
endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench for ex_mem_stage_reg: a branch-decision vector table plus
// hand-written reset, load, flush, stall and mid-run reset sequences.
module tb_ex_mem_stage_reg;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  ex_mem_stage_reg_if #(.DW(64), .RW(5)) bus ();

  ex_mem_stage_reg #(.DW(64), .RW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [3:0] nzcv;
    logic       branch;
    logic       cbz;
    logic       cbnz;
    logic       uncond;
    logic       alu_z;
    logic [3:0] cond;
    logic       exp;
  } br_vec_t;

  br_vec_t vecs[24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.flush = 0;
    bus.alu_result = '0; bus.alu_n = 0; bus.alu_z = 0; bus.alu_c = 0; bus.alu_v = 0;
    bus.rd2_EX = '0; bus.targetReg_EX = '0; bus.pc_plus4_EX = '0;
    bus.br_target = '0; bus.rd1_EX = '0;
    bus.set_flags_EX = 0; bus.branch_EX = 0; bus.uncondBr_EX = 0;
    bus.branchReg_EX = 0; bus.branchLink_EX = 0;
    bus.memToReg_EX = 0; bus.memWrite_EX = 0; bus.memRead_EX = 0; bus.RegWrite_EX = 0;
    bus.cbz_EX = 0; bus.cbnz_EX = 0; bus.cond_EX = '0;
  endtask

  task automatic check_mem_zero(input string tag);
    check({tag, " alu_result_MEM"}, bus.alu_result_MEM, 64'h0);
    check({tag, " rd2_MEM"}, bus.rd2_MEM, 64'h0);
    check({tag, " pc_plus4_MEM"}, bus.pc_plus4_MEM, 64'h0);
    check({tag, " targetReg_MEM"}, 64'(bus.targetReg_MEM), 64'h0);
    check({tag, " ctrl_MEM"}, 64'({bus.memToReg_MEM, bus.memWrite_MEM, bus.memRead_MEM,
                                   bus.RegWrite_MEM, bus.branchLink_MEM}), 64'h0);
    check({tag, " valid_MEM"}, 64'(bus.valid_MEM), 64'h0);
  endtask

  function automatic br_vec_t mk(input string name, input logic [3:0] nzcv, input logic branch,
                                 input logic cbz, input logic cbnz, input logic uncond,
                                 input logic alu_z, input logic [3:0] cond, input logic exp);
    br_vec_t v;
    v.name = name; v.nzcv = nzcv; v.branch = branch; v.cbz = cbz; v.cbnz = cbnz;
    v.uncond = uncond; v.alu_z = alu_z; v.cond = cond; v.exp = exp;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //              name        nzcv    br cbz cbnz unc az cond   exp
    vecs[0]  = mk("EQ z1",    4'b0100, 1, 0, 0, 0, 0, 4'h0, 1);
    vecs[1]  = mk("NE z1",    4'b0100, 1, 0, 0, 0, 0, 4'h1, 0);
    vecs[2]  = mk("HS c1",    4'b0010, 1, 0, 0, 0, 0, 4'h2, 1);
    vecs[3]  = mk("LO c1",    4'b0010, 1, 0, 0, 0, 0, 4'h3, 0);
    vecs[4]  = mk("MI n1",    4'b1000, 1, 0, 0, 0, 0, 4'h4, 1);
    vecs[5]  = mk("PL n1",    4'b1000, 1, 0, 0, 0, 0, 4'h5, 0);
    vecs[6]  = mk("VS v1",    4'b0001, 1, 0, 0, 0, 0, 4'h6, 1);
    vecs[7]  = mk("VC v0",    4'b0000, 1, 0, 0, 0, 0, 4'h7, 1);
    vecs[8]  = mk("HI c1z0",  4'b0010, 1, 0, 0, 0, 0, 4'h8, 1);
    vecs[9]  = mk("HI c1z1",  4'b0110, 1, 0, 0, 0, 0, 4'h8, 0);
    vecs[10] = mk("LS c1z1",  4'b0110, 1, 0, 0, 0, 0, 4'h9, 1);
    vecs[11] = mk("GE n1v1",  4'b1001, 1, 0, 0, 0, 0, 4'hA, 1);
    vecs[12] = mk("LT n1v0",  4'b1000, 1, 0, 0, 0, 0, 4'hB, 1);
    vecs[13] = mk("GT z0nv0", 4'b0000, 1, 0, 0, 0, 0, 4'hC, 1);
    vecs[14] = mk("GT z1",    4'b0100, 1, 0, 0, 0, 0, 4'hC, 0);
    vecs[15] = mk("LE z1",    4'b0100, 1, 0, 0, 0, 0, 4'hD, 1);
    vecs[16] = mk("AL",       4'b0000, 1, 0, 0, 0, 0, 4'hE, 1);
    vecs[17] = mk("AL 0xF",   4'b0000, 1, 0, 0, 0, 0, 4'hF, 1);
    vecs[18] = mk("CBZ z1",   4'b0000, 1, 1, 0, 0, 1, 4'h0, 1);
    vecs[19] = mk("CBZ z0",   4'b0100, 1, 1, 0, 0, 0, 4'h0, 0);
    vecs[20] = mk("CBNZ z0",  4'b0000, 1, 1, 1, 0, 0, 4'h0, 1);
    vecs[21] = mk("CBNZ z1",  4'b0000, 1, 1, 1, 0, 1, 4'h0, 0);
    vecs[22] = mk("B uncond", 4'b0000, 0, 0, 0, 1, 0, 4'h0, 1);
    vecs[23] = mk("no br",    4'b0000, 0, 0, 0, 0, 0, 4'hE, 0);

    // Reset with random inputs for two edges.
    reset_n = 1'b0;
    clear_inputs();
    bus.alu_result = {$urandom, $urandom}; bus.rd2_EX = {$urandom, $urandom};
    bus.pc_plus4_EX = {$urandom, $urandom}; bus.targetReg_EX = 5'($urandom);
    bus.RegWrite_EX = 1; bus.memRead_EX = 1; bus.memWrite_EX = 1; bus.memToReg_EX = 1;
    bus.branchLink_EX = 1; bus.set_flags_EX = 1;
    bus.alu_n = 1; bus.alu_z = 1; bus.alu_c = 1; bus.alu_v = 1;
    tick();
    tick();
    check_mem_zero("reset");
    check("reset flags_q", 64'(bus.flags_q), 64'h0);
    clear_inputs();
    bus.branch_EX = 1; bus.cond_EX = 4'h1;
    #1 check("reset NE on zero flags", 64'(bus.br_taken), 64'h1);
    reset_n = 1'b1;

    // Full load of data and control.
    clear_inputs();
    bus.alu_result = 64'hDEAD_BEEF_0000_1234; bus.rd2_EX = 64'h0123_4567_89AB_CDEF;
    bus.pc_plus4_EX = 64'h0000_0000_0040_0008; bus.targetReg_EX = 5'd17;
    bus.memToReg_EX = 1; bus.memRead_EX = 1; bus.RegWrite_EX = 1; bus.branchLink_EX = 1;
    tick();
    check("load alu_result_MEM", bus.alu_result_MEM, 64'hDEAD_BEEF_0000_1234);
    check("load rd2_MEM", bus.rd2_MEM, 64'h0123_4567_89AB_CDEF);
    check("load pc_plus4_MEM", bus.pc_plus4_MEM, 64'h0000_0000_0040_0008);
    check("load targetReg_MEM", 64'(bus.targetReg_MEM), 64'd17);
    check("load ctrl_MEM", 64'({bus.memToReg_MEM, bus.memWrite_MEM, bus.memRead_MEM,
                                bus.RegWrite_MEM, bus.branchLink_MEM, bus.valid_MEM}), 64'b101111);
    check("load flags untouched", 64'(bus.flags_q), 64'h0);
    clear_inputs();
    bus.memWrite_EX = 1;
    tick();
    check("load2 ctrl_MEM", 64'({bus.memToReg_MEM, bus.memWrite_MEM, bus.memRead_MEM,
                                 bus.RegWrite_MEM, bus.branchLink_MEM, bus.valid_MEM}), 64'b010001);

    // Branch-decision table: load flags, then present the branch while the
    // same-cycle ALU flags are the inverse and set_flags_EX is asserted.
    for (int i = 0; i < 24; i++) begin
      clear_inputs();
      bus.set_flags_EX = 1;
      {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = vecs[i].nzcv;
      tick();
      check({vecs[i].name, " flags_q"}, 64'(bus.flags_q), 64'(vecs[i].nzcv));
      clear_inputs();
      bus.set_flags_EX = 1;
      {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = ~vecs[i].nzcv;
      if (vecs[i].cbz) bus.alu_z = vecs[i].alu_z;
      bus.branch_EX = vecs[i].branch; bus.cbz_EX = vecs[i].cbz;
      bus.cbnz_EX = vecs[i].cbnz; bus.uncondBr_EX = vecs[i].uncond;
      bus.cond_EX = vecs[i].cond;
      #1 check({vecs[i].name, " br_taken"}, 64'(bus.br_taken), 64'(vecs[i].exp));
    end

    // SUBS sets N, then B.LT / B.GE with zero bubbles.
    clear_inputs();
    bus.alu_n = 1; bus.set_flags_EX = 1; bus.RegWrite_EX = 1;
    tick();
    check("subs flags_q", 64'(bus.flags_q), 64'b1000);
    clear_inputs();
    bus.branch_EX = 1; bus.cond_EX = 4'hB;
    #1 check("b.lt taken", 64'(bus.br_taken), 64'h1);
    bus.cond_EX = 4'hA;
    #1 check("b.ge not taken", 64'(bus.br_taken), 64'h0);

    // Redirect target selection.
    bus.branchReg_EX = 1; bus.rd1_EX = 64'h1000; bus.br_target = 64'h2000;
    #1 check("BR target", bus.pc_next_target, 64'h1000);
    bus.branchReg_EX = 0;
    #1 check("rel target", bus.pc_next_target, 64'h2000);

    // Flush: bubble inserted, flags held.
    clear_inputs();
    bus.RegWrite_EX = 1; bus.alu_result = 64'h2A; bus.set_flags_EX = 1;
    bus.alu_z = 1; bus.alu_c = 1; bus.flush = 1;
    tick();
    check("flush RegWrite_MEM", 64'(bus.RegWrite_MEM), 64'h0);
    check("flush alu_result_MEM", bus.alu_result_MEM, 64'h0);
    check("flush valid_MEM", 64'(bus.valid_MEM), 64'h0);
    check("flush flags held", 64'(bus.flags_q), 64'b1000);

    // Stall holds for three edges, then releases.
    clear_inputs();
    bus.alu_result = 64'h10; bus.RegWrite_EX = 1;
    tick();
    check("pre-stall alu", bus.alu_result_MEM, 64'h10);
    bus.alu_result = 64'h20; bus.RegWrite_EX = 0; bus.stall = 1;
    bus.set_flags_EX = 1; bus.alu_c = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall alu held", bus.alu_result_MEM, 64'h10);
    end
    check("stall RegWrite held", 64'(bus.RegWrite_MEM), 64'h1);
    check("stall flags held", 64'(bus.flags_q), 64'b1000);
    bus.stall = 0; bus.set_flags_EX = 0;
    tick();
    check("stall release alu", bus.alu_result_MEM, 64'h20);
    check("stall release RegWrite", 64'(bus.RegWrite_MEM), 64'h0);

    // Stall and flush together: hold wins.
    bus.stall = 1; bus.flush = 1; bus.alu_result = 64'h30;
    bus.set_flags_EX = 1; bus.alu_v = 1;
    tick();
    check("stall+flush alu held", bus.alu_result_MEM, 64'h20);
    check("stall+flush valid held", 64'(bus.valid_MEM), 64'h1);
    check("stall+flush flags held", 64'(bus.flags_q), 64'b1000);
    bus.stall = 0;
    tick();
    check("flush after stall valid", 64'(bus.valid_MEM), 64'h0);
    check("flush after stall alu", bus.alu_result_MEM, 64'h0);

    // Reset mid-operation, then resume loading.
    clear_inputs();
    bus.set_flags_EX = 1; bus.alu_z = 1; bus.alu_c = 1; bus.alu_result = 64'h77;
    bus.RegWrite_EX = 1; bus.targetReg_EX = 5'd3;
    tick();
    check("pre-reset valid", 64'(bus.valid_MEM), 64'h1);
    check("pre-reset flags", 64'(bus.flags_q), 64'b0110);
    reset_n = 1'b0;
    tick();
    check_mem_zero("mid reset");
    check("mid reset flags_q", 64'(bus.flags_q), 64'h0);
    reset_n = 1'b1;
    clear_inputs();
    bus.alu_result = 64'h55; bus.memRead_EX = 1;
    tick();
    check("resume valid", 64'(bus.valid_MEM), 64'h1);
    check("resume alu", bus.alu_result_MEM, 64'h55);
    check("resume memRead", 64'(bus.memRead_MEM), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
